hilo_muldiv_unit: RTL

//   Multi-cycle MIPS multiply/divide engine and owner of the architectural HI/LO registers.
//   The datapath issues MULT/MULTU/DIV/DIVU/MTHI/MTLO to this unit.

---
 rtl/hilo_muldiv_unit.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/hilo_muldiv_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU engine owning the HI/LO registers.
// Optional single-cycle multiply path: define HILO_FAST_MULT_EN.
module hilo_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_ITER, S_FIX} state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          count_q;
    logic [2*WIDTH-1:0]     acc_q;
    logic [WIDTH-1:0]       opnd_q;
    logic [WIDTH-1:0]       rs_raw_q;
    logic                   is_div_q;
    logic                   neg_a_q, neg_b_q;
    logic                   div_zero_q;
    logic [WIDTH-1:0]       hi_q, lo_q;
    logic                   done_q;

    // Operand conditioning at issue
    logic                   rs_neg, rt_neg;
    logic [WIDTH-1:0]       rs_abs, rt_abs;

    assign rs_neg = ~op[0] & rs_data[WIDTH-1];
    assign rt_neg = ~op[0] & rt_data[WIDTH-1];
    assign rs_abs = rs_neg ? (~rs_data + 1'b1) : rs_data;
    assign rt_abs = rt_neg ? (~rt_data + 1'b1) : rt_data;

    // One radix-2 step: acc holds {product-high, multiplier} or {remainder, quotient}
    logic [WIDTH:0]         mul_sum;
    logic [WIDTH:0]         div_shift;
    logic [WIDTH:0]         div_diff;
    logic                   div_ok;
    logic [2*WIDTH-1:0]     iter_acc;

    always_comb begin
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        div_shift = acc_q[2*WIDTH-1:WIDTH-1];
        div_diff  = div_shift - {1'b0, opnd_q};
        div_ok    = ~div_diff[WIDTH];
        if (is_div_q)
            iter_acc = {(div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                        acc_q[WIDTH-2:0], div_ok};
        else
            iter_acc = {mul_sum, acc_q[WIDTH-1:1]};
    end

    // Sign correction and special cases applied in FIX
    logic [2*WIDTH-1:0]     fix_raw;
    logic [2*WIDTH-1:0]     mul_res;
    logic [WIDTH-1:0]       fix_hi, fix_lo;

    always_comb begin
`ifdef HILO_FAST_MULT_EN
        if (is_div_q)
            fix_raw = acc_q;
        else
            fix_raw = {{WIDTH{1'b0}}, opnd_q} * {{WIDTH{1'b0}}, acc_q[WIDTH-1:0]};
`else
        fix_raw = acc_q;
`endif
        mul_res = (neg_a_q ^ neg_b_q) ? (~fix_raw + 1'b1) : fix_raw;
        if (!is_div_q) begin
            fix_hi = mul_res[2*WIDTH-1:WIDTH];
            fix_lo = mul_res[WIDTH-1:0];
        end else if (div_zero_q) begin
            fix_hi = rs_raw_q;
            fix_lo = '1;
        end else begin
            fix_hi = neg_a_q ? (~fix_raw[2*WIDTH-1:WIDTH] + 1'b1) : fix_raw[2*WIDTH-1:WIDTH];
            fix_lo = (neg_a_q ^ neg_b_q) ? (~fix_raw[WIDTH-1:0] + 1'b1) : fix_raw[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
`ifdef HILO_FAST_MULT_EN
                    state_d = op[1] ? S_ITER : S_FIX;
`else
                    state_d = S_ITER;
`endif
                end
            end
            S_ITER:  if (count_q == CW'(WIDTH-1)) state_d = S_FIX;
            S_FIX:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q != S_IDLE);
        done = done_q;
        hi   = hi_q;
        lo   = lo_q;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count_q    <= '0;
            acc_q      <= '0;
            opnd_q     <= '0;
            rs_raw_q   <= '0;
            is_div_q   <= 1'b0;
            neg_a_q    <= 1'b0;
            neg_b_q    <= 1'b0;
            div_zero_q <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            done_q     <= 1'b0;
        end else begin
            done_q <= (state_q == S_FIX);
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        count_q    <= '0;
                        is_div_q   <= op[1];
                        neg_a_q    <= rs_neg;
                        neg_b_q    <= rt_neg;
                        div_zero_q <= (rt_data == '0);
                        rs_raw_q   <= rs_data;
                        opnd_q     <= op[1] ? rt_abs : rs_abs;
                        acc_q      <= {{WIDTH{1'b0}}, (op[1] ? rs_abs : rt_abs)};
                    end else begin
                        if (mthi) hi_q <= wdata;
                        if (mtlo) lo_q <= wdata;
                    end
                end
                S_ITER: begin
                    acc_q   <= iter_acc;
                    count_q <= count_q + 1'b1;
                end
                S_FIX: begin
                    hi_q <= fix_hi;
                    lo_q <= fix_lo;
                end
                default: ;
            endcase
        end
    end

endmodule
